// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with a registered ALU, a local NZCV register and an iterative MUL/MLA unit.
// A multiply holds busy high for MUL_ITER cycles after it is accepted, then writes its result.
module exec_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1,
    parameter int RD_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_d,
    output logic             ready_d,
    input  logic             flush_e,
    input  logic             hold,
    input  logic [3:0]       alu_ctrl_d,
    input  logic             is_mul_d,
    input  logic             is_mla_d,
    input  logic             setf_d,
    input  logic [WIDTH-1:0] op_a_d,
    input  logic [WIDTH-1:0] op_b_d,
    input  logic [WIDTH-1:0] acc_d,
    input  logic [RD_W-1:0]  rd_d,
    output logic             valid_e,
    output logic [WIDTH-1:0] result_e,
    output logic [RD_W-1:0]  rd_e,
    output logic [3:0]       flags_e,
    output logic             busy
);
    localparam int MUL_ITER = WIDTH / MUL_BITS;
    localparam int CW = $clog2(MUL_ITER);
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_prod, r_acc;
    logic r_setf;
    logic [RD_W-1:0] r_rd;
    logic w_accept, w_last, w_arith, w_cin;
    logic [WIDTH-1:0] w_x, w_y, w_res, w_pp, w_prod_nxt, w_mul_res;
    logic [WIDTH:0] w_sum;
    logic [3:0] w_alu_flags;

    assign busy       = r_state == S_MUL;
    assign ready_d    = !busy && !hold;
    assign w_accept   = valid_d && ready_d && !flush_e;
    assign w_last     = busy && r_cnt == CW'(MUL_ITER - 1);
    assign w_pp       = r_mcand * {{(WIDTH-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
    assign w_prod_nxt = r_prod + w_pp;
    assign w_mul_res  = w_prod_nxt + r_acc;

    // Every add/subtract form is A' + B' + cin so one adder yields carry and overflow.
    always_comb begin
        w_x     = (alu_ctrl_d == 4'd5) ? op_b_d : op_a_d;
        w_y     = (alu_ctrl_d == 4'd0 || alu_ctrl_d == 4'd6) ? op_b_d :
                  (alu_ctrl_d == 4'd5) ? ~op_a_d : ~op_b_d;
        w_cin   = (alu_ctrl_d == 4'd1 || alu_ctrl_d == 4'd5) ? 1'b1 :
                  (alu_ctrl_d == 4'd6 || alu_ctrl_d == 4'd7) ? flags_e[1] : 1'b0;
        w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
        w_arith = alu_ctrl_d inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7};
        case (alu_ctrl_d)
            4'd0, 4'd1, 4'd5, 4'd6, 4'd7: w_res = w_sum[WIDTH-1:0];
            4'd2:    w_res = op_a_d & op_b_d;
            4'd3:    w_res = op_a_d | op_b_d;
            4'd4:    w_res = op_a_d ^ op_b_d;
            4'd8:    w_res = op_b_d;
            4'd9:    w_res = ~op_b_d;
            default: w_res = '0;
        endcase
        w_alu_flags = {w_res[WIDTH-1], w_res == '0,
                       w_arith ? w_sum[WIDTH] : flags_e[1],
                       w_arith ? (w_x[WIDTH-1] == w_y[WIDTH-1] && w_sum[WIDTH-1] != w_x[WIDTH-1]) : flags_e[0]};
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_e)
            w_state_nxt = S_IDLE;
        else if (!hold)
            w_state_nxt = (r_state == S_IDLE) ? ((w_accept && is_mul_d) ? S_MUL : S_IDLE) :
                          (w_last ? S_IDLE : S_MUL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            valid_e  <= 1'b0;
            result_e <= '0;
            rd_e     <= '0;
            flags_e  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_e) begin
                valid_e <= 1'b0;
                r_cnt   <= '0;
            end else if (!hold) begin
                valid_e <= (w_accept && !is_mul_d) || w_last;
                if (w_accept && is_mul_d) begin
                    r_mcand  <= op_a_d;
                    r_mplier <= op_b_d;
                    r_prod   <= '0;
                    r_acc    <= is_mla_d ? acc_d : '0;
                    r_setf   <= setf_d;
                    r_rd     <= rd_d;
                    r_cnt    <= '0;
                end else if (w_accept) begin
                    result_e <= w_res;
                    rd_e     <= rd_d;
                    if (setf_d && alu_ctrl_d <= 4'd9)
                        flags_e <= w_alu_flags;
                end else if (busy) begin
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_prod   <= w_prod_nxt;
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        result_e <= w_mul_res;
                        rd_e     <= r_rd;
                        if (r_setf)
                            flags_e[3:2] <= {w_mul_res[WIDTH-1], w_mul_res == '0};
                    end
                end
            end
        end
    end
endmodule
